debug_mem_access: RTL and testbench
===================================

// Module: debug_mem_access
// PURPOSE
//  Memory-access sequencer directly downstream of the JTAG debug controller, in the cpu_clk domain.
//  Accepts one debug read/write command at a time for IMEM or DMEM and halts the CPU core.
//  Performs a single req/gnt/rvalid bus transaction on the debug memory port.
//  Returns read data and a status word that the controller loads into its JTAG capture register.
// PARAMETERS
//  ADDR_W      32    memory address width
//  DATA_W      32    memory data width
//  TIMEOUT     255   max cycles waiting for cpu_halted, mem_gnt or mem_rvalid before abort (1..2^CNT_W-1)
//  CNT_W       8     width of the timeout counter
// PORTS
//  cpu_clk       in   1       core clock
//  cpu_rstn      in   1       async active-low reset
//  cmd_valid     in   1       command offered (single-cycle pulse or held)
//  cmd_ready     out  1       block idle and able to take a command
//  cmd_write     in   1       1=write, 0=read
//  cmd_dmem      in   1       1=DMEM, 0=IMEM
//  cmd_addr      in   ADDR_W  target address
//  cmd_wdata     in   DATA_W  write data
//  cpu_halt_req  out  1       request the core to stall its memory ports
//  cpu_halted    in   1       core acknowledges the stall
//  mem_req       out  1       bus request, held until mem_gnt
//  mem_gnt       in   1       request accepted this cycle
//  mem_we        out  1       write enable, qualified by mem_req
//  mem_dmem      out  1       1=DMEM bank, 0=IMEM bank
//  mem_addr      out  ADDR_W  bus address
//  mem_wdata     out  DATA_W  bus write data
//  mem_rvalid    in   1       read data valid (reads only, >=1 cycle after gnt)
//  mem_rdata     in   DATA_W  read data
//  rsp_valid     out  1       one-cycle pulse: command finished
//  rsp_rdata     out  DATA_W  last read data, held until next read completes
//  rsp_status    out  2       00 ok, 01 halt timeout, 10 gnt timeout, 11 rvalid timeout (held)
// BEHAVIOUR
//  Reset values: cmd_ready=1; all other outputs 0; state IDLE; timeout counter 0.
//  Handshake: command accepted on the cycle cmd_valid & cmd_ready are both high.
//   - cmd_write/cmd_dmem/cmd_addr/cmd_wdata are registered on accept.
//   - cmd_ready drops the following cycle and stays low until rsp_valid.
//  FSM states:
//   IDLE  -> HALT on accept; cpu_halt_req=1 registered.
//   HALT  -> REQ when cpu_halted=1. If cpu_halted is already 1, HALT lasts exactly one cycle.
//   REQ   -> mem_req=1 with registered addr/we/dmem/wdata, held stable until mem_gnt.
//            On gnt: writes -> DONE; reads -> RDATA.
//   RDATA -> DONE when mem_rvalid=1; mem_rdata captured into rsp_rdata that cycle.
//            mem_rvalid in the same cycle as gnt is ignored; only rvalid in RDATA is accepted.
//   DONE  -> one cycle: rsp_valid=1, cpu_halt_req=0, cmd_ready=1 -> IDLE.
//  Latency with zero-wait memory: accept@0, halt_req@1, mem_req@2, gnt@2, rvalid@3.
//   - write: rsp_valid@3.
//   - read: rsp_valid@4.
//  Timeout counter: cleared on each state entry, increments every cycle in HALT/REQ/RDATA.
//   - At TIMEOUT, go to DONE with the matching rsp_status, mem_req dropped.
//   - rsp_rdata unchanged on a timed-out read.
//  rsp_status reflects the most recent command; it is written 00 on successful completion.
//  cpu_halt_req is only asserted by this block around a command.
//   - It does not model the persistent CPUHALT state; the upstream controller ORs its own halt in.
//  cmd_valid while busy: ignored, never queued.
//   - A new command may be accepted in the cycle after the DONE cycle (IDLE).
//  Reset mid-operation: all outputs return to reset values immediately.
//   - An outstanding bus transaction is abandoned; the memory tolerates an unacknowledged req.
//  mem_addr/mem_wdata/mem_we are don't-care when mem_req=0; drive 0 there for waveform clarity.
// STRUCTURE
//  Package debug_pkg: FSM state enum, rsp_status encodings (DBG_ST_OK/HALT_TO/GNT_TO/RVALID_TO).
//   - The same package holds the DEBUGOP_* opcode constants shared with the debug controller.
//  Single module, no sub-modules; the timeout counter is inline.
// TESTING
//  1. Write, zero-wait (gnt same cycle, halted=1):
//     accept @0 -> mem_req@2 with we=1, addr 0x10, wdata 0xDEADBEEF -> rsp_valid@3, status 00.
//  2. Read IMEM 0x4, gnt after 3 cycles, rvalid 2 cycles later with 0x12345678:
//     -> rsp_rdata=0x12345678, status 00, addr held stable throughout.
//  3. cpu_halted never asserted, TIMEOUT=4:
//     -> no mem_req ever; rsp_valid after 4 HALT cycles; status 01; halt_req deasserts.
//  4. Read with rvalid never asserted:
//     -> status 11; rsp_rdata retains the previous value; cmd_ready returns to 1.
//  5. cmd_valid pulsed every cycle during a transaction:
//     -> exactly one transaction per rsp_valid; second command accepted only in IDLE.
//  6. cpu_rstn asserted while in RDATA:
//     -> all outputs 0, cmd_ready=1 after release; next read completes normally.

Source files
------------

// File: rtl/debug_mem_access_pkg.sv
// Shared types for the debug memory-access path: FSM states, response status codes
// and the opcode constants also used by the JTAG debug controller.
package debug_mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_REQ   = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DBG_ST_OK        = 2'b00,
    DBG_ST_HALT_TO   = 2'b01,
    DBG_ST_GNT_TO    = 2'b10,
    DBG_ST_RVALID_TO = 2'b11
  } status_e;

  localparam logic [3:0] DEBUGOP_NOP      = 4'h0;
  localparam logic [3:0] DEBUGOP_CPUHALT  = 4'h1;
  localparam logic [3:0] DEBUGOP_CPURUN   = 4'h2;
  localparam logic [3:0] DEBUGOP_IMEM_RD  = 4'h4;
  localparam logic [3:0] DEBUGOP_IMEM_WR  = 4'h5;
  localparam logic [3:0] DEBUGOP_DMEM_RD  = 4'h6;
  localparam logic [3:0] DEBUGOP_DMEM_WR  = 4'h7;

endpackage

// File: rtl/debug_mem_access_if.sv
// Command, core-halt, memory-bus and response signals of the debug memory sequencer.
// The slave modport is the sequencer's view; master is the controller/core/memory side.
interface debug_mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_dmem;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              cpu_halt_req;
  logic              cpu_halted;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic              mem_dmem;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_status;

  modport slave (
    input  cmd_valid, cmd_write, cmd_dmem, cmd_addr, cmd_wdata,
    input  cpu_halted, mem_gnt, mem_rvalid, mem_rdata,
    output cmd_ready, cpu_halt_req,
    output mem_req, mem_we, mem_dmem, mem_addr, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_status
  );

  modport master (
    output cmd_valid, cmd_write, cmd_dmem, cmd_addr, cmd_wdata,
    output cpu_halted, mem_gnt, mem_rvalid, mem_rdata,
    input  cmd_ready, cpu_halt_req,
    input  mem_req, mem_we, mem_dmem, mem_addr, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_status
  );

endinterface

// File: rtl/debug_mem_access.sv
// Debug memory-access sequencer: halts the core, runs one req/gnt/rvalid bus transaction
// and reports read data plus a status word back to the JTAG debug controller.
module debug_mem_access
  import debug_mem_access_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               cpu_clk,
  input  logic               cpu_rstn,
  debug_mem_access_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              halt_req_q, halt_req_d;
  logic              mem_req_q, mem_req_d;
  logic              we_q, we_d;
  logic              dmem_q, dmem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  status_e           rsp_status_q, rsp_status_d;

  logic accept;
  logic timeout_hit;

  // cmd_ready is also high in DONE, but a command is only taken from IDLE
  assign accept      = bus.cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    halt_req_d   = halt_req_q;
    mem_req_d    = mem_req_q;
    we_d         = we_q;
    dmem_d       = dmem_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_HALT;
          halt_req_d = 1'b1;
          we_d       = bus.cmd_write;
          dmem_d     = bus.cmd_dmem;
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
        end
      end
      ST_HALT: begin
        if (bus.cpu_halted) begin
          state_d   = ST_REQ;
          mem_req_d = 1'b1;
        end else if (timeout_hit) begin
          state_d      = ST_DONE;
          rsp_status_d = DBG_ST_HALT_TO;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          if (we_q) begin
            state_d      = ST_DONE;
            rsp_status_d = DBG_ST_OK;
          end else begin
            state_d = ST_RDATA;
          end
        end else if (timeout_hit) begin
          mem_req_d    = 1'b0;
          state_d      = ST_DONE;
          rsp_status_d = DBG_ST_GNT_TO;
        end
      end
      ST_RDATA: begin
        if (bus.mem_rvalid) begin
          state_d      = ST_DONE;
          rsp_rdata_d  = bus.mem_rdata;
          rsp_status_d = DBG_ST_OK;
        end else if (timeout_hit) begin
          state_d      = ST_DONE;
          rsp_status_d = DBG_ST_RVALID_TO;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rsp_valid_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      halt_req_d = 1'b0;
    end
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);

    // Counter restarts on every state entry and only runs in the waiting states
    if ((state_d == state_q) &&
        (state_q == ST_HALT || state_q == ST_REQ || state_q == ST_RDATA)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b1;
      halt_req_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      we_q         <= 1'b0;
      dmem_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= DBG_ST_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      halt_req_q   <= halt_req_d;
      mem_req_q    <= mem_req_d;
      we_q         <= we_d;
      dmem_q       <= dmem_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.cpu_halt_req = halt_req_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_req_q & we_q;
  assign bus.mem_dmem     = mem_req_q & dmem_q;
  assign bus.mem_addr     = mem_req_q ? addr_q  : '0;
  assign bus.mem_wdata    = mem_req_q ? wdata_q : '0;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_status   = rsp_status_q;

endmodule

// File: tb/tb_debug_mem_access.sv
// Scoreboard bench for debug_mem_access: directed commands push expected responses,
// a forked monitor pops them on rsp_valid and also polices the memory bus.
module tb_debug_mem_access;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  status;
  } exp_t;

  logic cpu_clk;
  logic cpu_rstn;

  debug_mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  debug_mem_access #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .cpu_clk (cpu_clk),
    .cpu_rstn(cpu_rstn),
    .bus     (bus)
  );

  int   checks;
  int   errors;
  int   rsp_count;
  int   exp_rsp;
  exp_t sb_q[$];

  logic        exp_we;
  logic        exp_dmem;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        allow_req;

  int          gnt_delay;
  int          rvalid_delay;
  logic        gnt_never;
  logic        rvalid_never;
  logic        spur_rvalid;
  logic [31:0] rdata_val;

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Memory model: answers mem_req after gnt_delay cycles, read data rvalid_delay cycles after gnt
  int   req_cnt;
  int   rv_cnt;
  logic rv_pending;
  always @(posedge cpu_clk) begin
    #2;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    if (!cpu_rstn) begin
      req_cnt    = 0;
      rv_pending = 1'b0;
    end else begin
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdata_val;
          rv_pending     = 1'b0;
        end else begin
          rv_cnt--;
        end
      end
      if (bus.mem_req && !gnt_never) begin
        if (req_cnt == gnt_delay) begin
          bus.mem_gnt = 1'b1;
          req_cnt     = 0;
          if (spur_rvalid) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hBAD0_BAD0;
          end
          if (!bus.mem_we && !rvalid_never) begin
            rv_pending = 1'b1;
            rv_cnt     = rvalid_delay - 1;
          end
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge cpu_clk);
      if (cpu_rstn) begin
        if (bus.rsp_valid) begin
          rsp_count++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid, expected none");
          end else begin
            e = sb_q.pop_front();
            checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            checkOutput("rsp_status", 64'(bus.rsp_status), 64'(e.status));
            checkOutput("rsp_cmd_ready", 64'(bus.cmd_ready), 64'd1);
          end
        end
        if (bus.mem_req) begin
          checks++;
          if (!allow_req || bus.mem_addr !== exp_addr || bus.mem_we !== exp_we ||
              bus.mem_dmem !== exp_dmem || bus.mem_wdata !== exp_wdata) begin
            errors++;
            $display("[TB] FAIL mem_bus: got req=1 addr=0x%0h we=%0b dmem=%0b wdata=0x%0h, expected allowed=%0b addr=0x%0h we=%0b dmem=%0b wdata=0x%0h",
                     bus.mem_addr, bus.mem_we, bus.mem_dmem, bus.mem_wdata,
                     allow_req, exp_addr, exp_we, exp_dmem, exp_wdata);
          end
        end
      end
    end
  endtask

  task automatic driveCmd(input logic wr, input logic dm, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus.cmd_write = wr;
    bus.cmd_dmem  = dm;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    exp_we    = wr;
    exp_dmem  = dm;
    exp_addr  = addr;
    exp_wdata = wr ? wdata : 32'h0;
  endtask

  // Issues one command (accepted at the returned-from edge) and queues its expected response
  task automatic applyStimulus(input logic wr, input logic dm, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] e_rdata,
                               input logic [1:0] e_status);
    @(posedge cpu_clk);
    #1;
    driveCmd(wr, dm, addr, wdata);
    sb_q.push_back('{rdata: e_rdata, status: e_status});
    exp_rsp++;
    @(posedge cpu_clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int target);
    int k;
    k = 0;
    while (rsp_count < target && k < 60) begin
      @(negedge cpu_clk);
      #1;
      k++;
    end
    checks++;
    if (rsp_count < target) begin
      errors++;
      $display("[TB] FAIL rsp_timeout: got %0d responses, expected %0d", rsp_count, target);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rsp_count    = 0;
    exp_rsp      = 0;
    allow_req    = 1'b1;
    exp_we       = 1'b0;
    exp_dmem     = 1'b0;
    exp_addr     = 32'h0;
    exp_wdata    = 32'h0;
    gnt_delay    = 0;
    rvalid_delay = 1;
    gnt_never    = 1'b0;
    rvalid_never = 1'b0;
    spur_rvalid  = 1'b0;
    rdata_val    = 32'h0;
    cpu_rstn       = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_dmem   = 1'b0;
    bus.cmd_addr   = 32'h0;
    bus.cmd_wdata  = 32'h0;
    bus.cpu_halted = 1'b1;

    fork
      monitorLoop();
    join_none

    $display("[TB] reset");
    repeat (3) @(posedge cpu_clk);
    #1;
    checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("rst_halt_req", 64'(bus.cpu_halt_req), 64'd0);
    checkOutput("rst_mem_req", 64'(bus.mem_req), 64'd0);
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    checkOutput("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
    cpu_rstn = 1'b1;

    $display("[TB] zero-wait write");
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 2'b00);
    @(negedge cpu_clk);
    checkOutput("w_c1_halt_req", 64'(bus.cpu_halt_req), 64'd1);
    checkOutput("w_c1_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    checkOutput("w_c1_mem_req", 64'(bus.mem_req), 64'd0);
    @(negedge cpu_clk);
    checkOutput("w_c2_mem_req", 64'(bus.mem_req), 64'd1);
    checkOutput("w_c2_mem_we", 64'(bus.mem_we), 64'd1);
    @(negedge cpu_clk);
    checkOutput("w_c3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("w_c3_halt_req", 64'(bus.cpu_halt_req), 64'd0);
    checkOutput("w_c3_mem_req", 64'(bus.mem_req), 64'd0);
    @(negedge cpu_clk);
    checkOutput("w_c4_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    waitRsp(exp_rsp);

    $display("[TB] zero-wait read");
    rdata_val = 32'hCAFE_F00D;
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 2'b00);
    repeat (3) @(negedge cpu_clk);
    checkOutput("r_c3_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge cpu_clk);
    checkOutput("r_c4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    waitRsp(exp_rsp);

    $display("[TB] read with gnt and rvalid delays");
    gnt_delay    = 3;
    rvalid_delay = 2;
    spur_rvalid  = 1'b1;
    rdata_val    = 32'h1234_5678;
    applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 2'b00);
    waitRsp(exp_rsp);
    gnt_delay    = 0;
    rvalid_delay = 1;
    spur_rvalid  = 1'b0;

    $display("[TB] halt timeout");
    bus.cpu_halted = 1'b0;
    allow_req      = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h0, 32'h1234_5678, 2'b01);
    repeat (4) @(negedge cpu_clk);
    checkOutput("ht_c4_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("ht_c4_halt_req", 64'(bus.cpu_halt_req), 64'd1);
    @(negedge cpu_clk);
    checkOutput("ht_c5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("ht_c5_halt_req", 64'(bus.cpu_halt_req), 64'd0);
    waitRsp(exp_rsp);
    bus.cpu_halted = 1'b1;
    allow_req      = 1'b1;

    $display("[TB] gnt timeout");
    gnt_never = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h50, 32'h1111_2222, 32'h1234_5678, 2'b10);
    waitRsp(exp_rsp);
    checkOutput("gt_mem_req_dropped", 64'(bus.mem_req), 64'd0);
    gnt_never = 1'b0;

    $display("[TB] rvalid timeout");
    rvalid_never = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h60, 32'h0, 32'h1234_5678, 2'b11);
    waitRsp(exp_rsp);
    @(negedge cpu_clk);
    checkOutput("rt_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    rvalid_never = 1'b0;

    $display("[TB] cmd_valid held through a transaction");
    @(posedge cpu_clk);
    #1;
    driveCmd(1'b1, 1'b1, 32'h30, 32'h0BAD_F00D);
    sb_q.push_back('{rdata: 32'h1234_5678, status: 2'b00});
    sb_q.push_back('{rdata: 32'h1234_5678, status: 2'b00});
    exp_rsp += 2;
    @(posedge cpu_clk);
    #1;
    repeat (3) @(negedge cpu_clk);
    checkOutput("bb_c3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    @(negedge cpu_clk);
    checkOutput("bb_c4_halt_req", 64'(bus.cpu_halt_req), 64'd0);
    @(posedge cpu_clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge cpu_clk);
    checkOutput("bb_c5_halt_req", 64'(bus.cpu_halt_req), 64'd1);
    checkOutput("bb_c5_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    waitRsp(exp_rsp);
    repeat (5) @(negedge cpu_clk);
    checkOutput("bb_rsp_count", 64'(rsp_count), 64'(exp_rsp));
    checkOutput("bb_idle_halt_req", 64'(bus.cpu_halt_req), 64'd0);

    $display("[TB] reset while in RDATA");
    rvalid_never = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h70, 32'h0, 32'h0, 2'b00);
    repeat (3) @(negedge cpu_clk);
    cpu_rstn = 1'b0;
    sb_q.delete();
    exp_rsp = rsp_count;
    #1;
    checkOutput("mr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("mr_halt_req", 64'(bus.cpu_halt_req), 64'd0);
    checkOutput("mr_mem_req", 64'(bus.mem_req), 64'd0);
    checkOutput("mr_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    checkOutput("mr_rsp_status", 64'(bus.rsp_status), 64'd0);
    @(posedge cpu_clk);
    #1;
    cpu_rstn     = 1'b1;
    rvalid_never = 1'b0;
    @(negedge cpu_clk);
    checkOutput("mr_release_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    rdata_val = 32'hA5A5_5A5A;
    applyStimulus(1'b0, 1'b0, 32'h74, 32'h0, 32'hA5A5_5A5A, 2'b00);
    waitRsp(exp_rsp);

    repeat (3) @(negedge cpu_clk);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
